// File: rtl/gzip_pkg.sv
// gzip_pkg: shared state encoding and field widths for the GZIP trailer path.
package gzip_pkg;
    typedef enum logic [1:0] {ACCEPT, LATCH, EMIT} gzip_state_e;
    localparam int GZIP_TRAILER_BYTES = 8;
    localparam int CRC32_W = 32;
    localparam int ISIZE_W = 32;
endpackage

// File: rtl/gzip_byte_serializer.sv
// gzip_byte_serializer: loads an NB-byte word and shifts it out LSB-first with valid/ready; last_out pulses on the final acceptance.
module gzip_byte_serializer #(
    parameter int NB = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_in,
    input  logic [NB*8-1:0] data_in,
    output logic [7:0]      byte_out,
    output logic            valid_out,
    input  logic            ready_in,
    output logic            last_out
);
    localparam int IW = $clog2(NB);
    logic [NB*8-1:0] shift_q, shift_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            valid_q, valid_d, arm_q, arm_d, fire;
    // Load primes a one-cycle arm stage so the first byte appears registered one cycle after load
    always_comb begin
        fire = valid_q & ready_in;
        last_out = fire & (idx_q == IW'(NB - 1));
        shift_d = load_in ? data_in : fire ? shift_q >> 8 : shift_q;
        idx_d = load_in ? '0 : fire ? idx_q + IW'(1) : idx_q;
        arm_d = load_in;
        valid_d = arm_q | (valid_q & ~last_out);
    end
    // Serializer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q <= '0;
            valid_q <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q <= idx_d;
            valid_q <= valid_d;
            arm_q <= arm_d;
        end
    end
    assign byte_out = shift_q[7:0];
    assign valid_out = valid_q;
endmodule

// File: rtl/gzip_trailer_gen.sv
// gzip_trailer_gen: counts payload bytes (ISIZE) and emits the RFC 1952 trailer CRC32 then ISIZE, little-endian.
// Optional: GZIP_TRAILER_OVF_FLAG_EN adds a sticky isize_ovf_out flag set when ISIZE wraps.
module gzip_trailer_gen
    import gzip_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_valid_in,
    input  logic               data_last_in,
    input  logic               flush_in,
    output logic               data_ready_out,
    input  logic [CRC32_W-1:0] crc32_in,
    output logic [7:0]         trailer_out,
    output logic               trailer_valid_out,
    input  logic               trailer_ready_in,
    output logic               trailer_done_out,
`ifdef GZIP_TRAILER_OVF_FLAG_EN
    output logic               isize_ovf_out,
`endif
    output logic               crc_restart_out
);
    gzip_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             load, last, done;
    // Next state and byte counter; LATCH waits one cycle for the CRC to absorb the last byte
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load = 1'b0;
        done = last & (state_q == EMIT);
        if (state_q == ACCEPT) begin
            if (data_valid_in) begin
                count_d = count_q + CNT_W'(1);
                state_d = data_last_in ? LATCH : ACCEPT;
            end else if (flush_in) begin
                state_d = LATCH;
            end
        end else if (state_q == LATCH) begin
            load = 1'b1;
            state_d = EMIT;
        end else if (done) begin
            count_d = '0;
            state_d = ACCEPT;
        end
    end
    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCEPT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end
    gzip_byte_serializer #(.NB(GZIP_TRAILER_BYTES)) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_in  (load),
        .data_in  ({ISIZE_W'(count_q), crc32_in}),
        .byte_out (trailer_out),
        .valid_out(trailer_valid_out),
        .ready_in (trailer_ready_in),
        .last_out (last)
    );
    assign data_ready_out = (state_q == ACCEPT);
    assign trailer_done_out = done;
    assign crc_restart_out = done;
`ifdef GZIP_TRAILER_OVF_FLAG_EN
    logic ovf_q, ovf_d;
    // Sticky wrap flag, cleared with the counter at done
    always_comb begin
        ovf_d = done ? 1'b0 : (state_q == ACCEPT && data_valid_in && &count_q) ? 1'b1 : ovf_q;
    end
    // Overflow flag register
    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end
    assign isize_ovf_out = ovf_q;
`endif
endmodule

// File: tb/tb_gzip_trailer_gen.sv
// tb_gzip_trailer_gen: directed bench driving a 32-bit and an 8-bit-counter instance in lockstep.
module tb_gzip_trailer_gen;
    logic        clk = 0, rst_n = 0, dv = 0, dl = 0, fl = 0, tr = 1;
    logic [31:0] crc = 0;
    logic [7:0]  ta, tb;
    logic        va, vb, da, db, ra, rb, rdya, rdyb;
`ifdef GZIP_TRAILER_OVF_FLAG_EN
    logic        oa, ob;
`endif
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    gzip_trailer_gen #(.CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_valid_in(dv), .data_last_in(dl), .flush_in(fl),
        .data_ready_out(rdya), .crc32_in(crc), .trailer_out(ta), .trailer_valid_out(va),
        .trailer_ready_in(tr), .trailer_done_out(da),
`ifdef GZIP_TRAILER_OVF_FLAG_EN
        .isize_ovf_out(oa),
`endif
        .crc_restart_out(ra));

    gzip_trailer_gen #(.CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_valid_in(dv), .data_last_in(dl), .flush_in(fl),
        .data_ready_out(rdyb), .crc32_in(crc), .trailer_out(tb), .trailer_valid_out(vb),
        .trailer_ready_in(tr), .trailer_done_out(db),
`ifdef GZIP_TRAILER_OVF_FLAG_EN
        .isize_ovf_out(ob),
`endif
        .crc_restart_out(rb));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input logic [31:0] c);
        crc = c;
        for (int i = 0; i < n; i++) begin
            dv = 1'b1;
            dl = (i == n - 1);
            tick();
        end
        dv = 1'b0;
        dl = 1'b0;
    endtask

    task automatic get_trailer(input string tag, input logic [63:0] ea, input logic [63:0] eb, input bit rnd);
        int n = 0, cyc = 0, dn = 0, rs = 0;
        bit hold = 0;
        logic [7:0] held = 0;
        logic [15:0] pat = 16'b1011_0010_1001_1101;
        while (n < 8 && cyc < 100) begin
            tr = rnd ? pat[cyc % 16] : 1'b1;
            #1;
            if (hold && va) check({tag, "_stable"}, ta, held);
            dn += int'(da) + int'(db);
            rs += int'(ra) + int'(rb);
            if (va && tr) begin
                check($sformatf("%s_a_b%0d", tag, n), ta, ea[n*8 +: 8]);
                check($sformatf("%s_b_b%0d", tag, n), tb, eb[n*8 +: 8]);
                check($sformatf("%s_done_b%0d", tag, n), {da, db}, (n == 7) ? 2'b11 : 2'b00);
                n++;
                hold = 0;
            end else begin
                hold = va;
                held = ta;
            end
            tick();
            cyc++;
        end
        tr = 1'b1;
        check({tag, "_bytes"}, n, 8);
        check({tag, "_done_cnt"}, dn, 2);
        check({tag, "_restart_cnt"}, rs, 2);
        check({tag, "_valid_drop"}, {va, vb}, 2'b00);
        check({tag, "_ready_back"}, {rdya, rdyb}, 2'b11);
    endtask

    initial begin
        tick();
        tick();
        check("rst_outs", {va, da, ra, ta}, 11'd0);
        check("rst_ready", rdya, 1'b1);
`ifdef GZIP_TRAILER_OVF_FLAG_EN
        check("rst_ovf", {oa, ob}, 2'b00);
`endif
        rst_n = 1'b1;
        tick();
        // "123456789": latency then trailer with continuous ready
        send(9, 32'hCBF43926);
        check("t1_latch_rdy", rdya, 1'b0);
        check("t1_latch_v", va, 1'b0);
        tick();
        check("t1_n1_v", va, 1'b0);
        tick();
        check("t1_n2_v", va, 1'b1);
        check("t1_n2_byte", ta, 8'h26);
        get_trailer("t1", {32'd9, 32'hCBF43926}, {32'd9, 32'hCBF43926}, 0);
        // zero-length member via flush
        tick();
        crc = 32'h0;
        fl = 1'b1;
        tick();
        fl = 1'b0;
        get_trailer("flush", 64'h0, 64'h0, 0);
        // toggling ready
        tick();
        send(9, 32'hCBF43926);
        get_trailer("tog", {32'd9, 32'hCBF43926}, {32'd9, 32'hCBF43926}, 1);
        // data_valid_in during LATCH/EMIT is ignored
        tick();
        send(5, 32'hA5A50001);
        dv = 1'b1;
        tr = 1'b0;
        tick();
        tick();
        tick();
        dv = 1'b0;
        tr = 1'b1;
        get_trailer("viol", {32'd5, 32'hA5A50001}, {32'd5, 32'hA5A50001}, 0);
        // 259 bytes: 8-bit counter wraps to 3
        tick();
        send(259, 32'h12345678);
`ifdef GZIP_TRAILER_OVF_FLAG_EN
        check("wrap_ovf_set", {oa, ob}, 2'b01);
`endif
        get_trailer("wrap", {32'd259, 32'h12345678}, {32'd3, 32'h12345678}, 0);
`ifdef GZIP_TRAILER_OVF_FLAG_EN
        check("wrap_ovf_clr", {oa, ob}, 2'b00);
`endif
        // reset after 3rd trailer byte
        tick();
        send(9, 32'hCBF43926);
        repeat (5) tick();
        check("rst_mid_byte3", ta, 8'hCB);
        rst_n = 1'b0;
        #1;
        check("rst_mid_nodone", {da, ra}, 2'b00);
        tick();
        check("rst_mid_after", {va, da, ra, rdya, ta}, {4'b0001, 8'h00});
        rst_n = 1'b1;
        tick();
        send(1, 32'hE8B7BE43);
        get_trailer("a", {32'd1, 32'hE8B7BE43}, {32'd1, 32'hE8B7BE43}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
